// File: rtl/uart_out_arbiter.sv
// Shares one UART character sink among NREQ producers. Each producer has a private
// FIFO, and the grant is held until a newline (or an idle timeout) so lines never interleave.
module uart_out_arbiter #(
  parameter int NREQ    = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255,
  parameter int DROP_CR = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_ch,
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  output logic [7:0]                out_ch,
  input  logic                      out_ready,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      owner_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(NREQ);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner_nxt, rr_ptr, rr_nxt, pick, cand;
  logic            found;
  logic [TW-1:0]   idle_cnt, idle_nxt;
  logic            pop_any;

  logic [7:0]      mem   [NREQ][DEPTH];
  logic [AW-1:0]   wptr  [NREQ];
  logic [AW-1:0]   rptr  [NREQ];
  logic [CW-1:0]   count [NREQ];
  logic [NREQ-1:0] nonempty, push, store, pop;

  // Ready is forced low while reset is held, regardless of FIFO state.
  always_comb begin
    nonempty  = '0;
    req_ready = '0;
    push      = '0;
    store     = '0;
    for (int i = 0; i < NREQ; i++) begin
      nonempty[i]  = (count[i] != '0);
      req_ready[i] = reset && (count[i] != CW'(DEPTH));
      push[i]      = req_valid[i] && req_ready[i];
      store[i]     = push[i] && !((DROP_CR != 0) && (req_ch[8*i +: 8] == 8'h0d));
    end
  end

  assign owner_valid = (state == OWN);
  assign out_valid   = (state == OWN) && (count[owner] != '0);
  assign out_ch      = out_valid ? mem[owner][rptr[owner]] : 8'h00;
  assign pop_any     = out_valid && out_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NREQ; i++)
      pop[i] = pop_any && (owner == OW'(i));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (store[i]) wptr[i] <= wptr[i] + AW'(1);
        if (pop[i])   rptr[i] <= rptr[i] + AW'(1);
        case ({store[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Character storage carries no reset; stale entries are never visible past the counts.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NREQ; i++)
      if (store[i]) mem[i][wptr[i]] <= req_ch[8*i +: 8];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // Scanning downward lets the lowest offset from rr_ptr win the pick.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    idle_nxt  = idle_cnt;
    pick      = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = OW'((int'(rr_ptr) + k) % NREQ);
      if (nonempty[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = OWN;
          owner_nxt = pick;
          idle_nxt  = '0;
        end
      end
      OWN: begin
        if (pop_any)
          idle_nxt = '0;
        else if (!out_valid && (idle_cnt != TW'(TIMEOUT)))
          idle_nxt = idle_cnt + TW'(1);
        if ((pop_any && (out_ch == 8'h0a)) ||
            ((TIMEOUT != 0) && (idle_cnt == TW'(TIMEOUT)))) begin
          state_nxt = IDLE;
          rr_nxt    = OW'((int'(owner) + 1) % NREQ);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Scoreboard bench for uart_out_arbiter: per-requester expected-character queues
// plus directed checks on grant order, latency, timeout, backpressure and reset.
module tb_uart_out_arbiter;

  localparam int NREQ    = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_ch;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [7:0]        out_ch;
  logic              out_ready;
  logic [1:0]        owner;
  logic              owner_valid;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;

  logic [7:0] exp_q [NREQ][$];
  logic [7:0] log_ch[$];
  int         log_own[$];
  int         log_cyc[$];
  logic       prev_stall = 1'b0;
  logic [7:0] held_ch = 8'h00;

  uart_out_arbiter #(
    .NREQ(NREQ), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DROP_CR(1)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
    .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready),
    .owner(owner), .owner_valid(owner_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sink side is checked before source side so a char can never be matched in its own push cycle.
  always @(negedge clock) begin
    if (reset) begin
      if (prev_stall) begin
        checkOutput("stall_valid", {31'h0, out_valid}, 32'h1);
        checkOutput("stall_hold", {24'h0, out_ch}, {24'h0, held_ch});
      end
      if (out_valid && out_ready) begin
        if (exp_q[owner].size() == 0)
          checkOutput("spurious_char", {24'h0, out_ch}, 32'h100);
        else
          checkOutput("char_order", {24'h0, out_ch}, {24'h0, exp_q[owner].pop_front()});
        log_ch.push_back(out_ch);
        log_own.push_back(int'(owner));
        log_cyc.push_back(cyc);
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i] && req_ch[8*i +: 8] != 8'h0d)
          exp_q[i].push_back(req_ch[8*i +: 8]);
      prev_stall = out_valid && !out_ready;
      held_ch    = out_ch;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [8*NREQ-1:0] chOn(input int i, input logic [7:0] c);
    logic [8*NREQ-1:0] r;
    r = '0;
    r[8*i +: 8] = c;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [8*NREQ-1:0] ch, input logic rdy);
    tick();
    req_valid = v;
    req_ch    = ch;
    out_ready = rdy;
  endtask

  task automatic clearBook();
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    log_ch.delete();
    log_own.delete();
    log_cyc.delete();
  endtask

  task automatic applyReset();
    tick();
    reset     = 1'b0;
    req_valid = '0;
    req_ch    = '0;
    out_ready = 1'b1;
    clearBook();
    waitCycles(2);
    reset = 1'b1;
  endtask

  task automatic checkDrained(input string tag);
    int total;
    total = 0;
    for (int i = 0; i < NREQ; i++) total += exp_q[i].size();
    checkOutput(tag, total, 0);
  endtask

  initial begin
    int t;
    logic [NREQ-1:0]   phase;
    logic [NREQ-1:0]   acc;
    logic [8*NREQ-1:0] chs;
    int lines[$];
    logic [7:0] ab[3];
    logic [7:0] acr[3];
    logic [7:0] to_c[7];
    int         to_o[7];

    ab   = '{8'h61, 8'h62, 8'h0a};
    acr  = '{8'h61, 8'h0d, 8'h0a};
    to_c = '{8'h61, 8'h62, 8'h63, 8'h7a, 8'h0a, 8'h64, 8'h0a};
    to_o = '{0, 0, 0, 1, 1, 0, 0};

    reset     = 1'b0;
    req_valid = '0;
    req_ch    = '0;
    out_ready = 1'b1;
    #2;
    checkOutput("rst_req_ready", {28'h0, req_ready}, 32'h0);
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_out_ch", {24'h0, out_ch}, 32'h0);
    checkOutput("rst_owner_valid", {31'h0, owner_valid}, 32'h0);
    checkOutput("rst_owner", {30'h0, owner}, 32'h0);
    waitCycles(2);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_ready", {28'h0, req_ready}, 32'hf);

    // Single line "hi\n" from requester 0.
    applyReset();
    applyStimulus(4'b0001, chOn(0, 8'h68), 1'b1);
    t = cyc;
    applyStimulus(4'b0001, chOn(0, 8'h69), 1'b1);
    @(negedge clock);
    checkOutput("hi_not_early", {31'h0, out_valid}, 32'h0);
    applyStimulus(4'b0001, chOn(0, 8'h0a), 1'b1);
    applyStimulus('0, '0, 1'b1);
    waitCycles(8);
    checkOutput("hi_count", log_ch.size(), 3);
    if (log_ch.size() == 3) begin
      checkOutput("hi_latency", log_cyc[0] - t, 2);
      checkOutput("hi_c0", {24'h0, log_ch[0]}, 32'h68);
      checkOutput("hi_c1", {24'h0, log_ch[1]}, 32'h69);
      checkOutput("hi_c2", {24'h0, log_ch[2]}, 32'h0a);
    end
    @(negedge clock);
    checkOutput("hi_released", {31'h0, owner_valid}, 32'h0);
    checkDrained("hi_drained");

    // Two simultaneous lines must come out whole, one after the other.
    applyReset();
    for (int k = 0; k < 3; k++)
      applyStimulus(4'b0011, chOn(0, ab[k]) | chOn(1, ab[k]), 1'b1);
    applyStimulus('0, '0, 1'b1);
    waitCycles(12);
    checkOutput("nil_count", log_ch.size(), 6);
    if (log_ch.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        checkOutput("nil_char", {24'h0, log_ch[k]}, {24'h0, ab[k % 3]});
        checkOutput("nil_owner", log_own[k], k / 3);
      end
      checkOutput("nil_handoff_gap", log_cyc[3] - log_cyc[2], 2);
    end
    checkDrained("nil_drained");

    // Every requester streams "x\n" lines; grants must rotate.
    applyReset();
    phase = '0;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NREQ; i++) chs[8*i +: 8] = phase[i] ? 8'h0a : 8'h78;
      applyStimulus('1, chs, 1'b1);
      @(negedge clock);
      acc   = req_valid & req_ready;
      phase = phase ^ acc;
    end
    applyStimulus('0, '0, 1'b1);
    waitCycles(150);
    lines.delete();
    foreach (log_ch[k]) if (log_ch[k] == 8'h0a) lines.push_back(log_own[k]);
    checkOutput("rr_enough_lines", {31'h0, lines.size() >= 8}, 32'h1);
    if (lines.size() >= 8)
      for (int k = 0; k < 8; k++) checkOutput("rr_grant", lines[k], k % 4);
    checkDrained("rr_drained");

    // Carriage return dropped while the sink toggles ready every cycle.
    applyReset();
    for (int k = 0; k < 20; k++) begin
      if (k < 3) applyStimulus(4'b0100, chOn(2, acr[k]), k[0]);
      else       applyStimulus('0, '0, k[0]);
    end
    applyStimulus('0, '0, 1'b1);
    waitCycles(5);
    checkOutput("cr_count", log_ch.size(), 2);
    if (log_ch.size() == 2) begin
      checkOutput("cr_c0", {24'h0, log_ch[0]}, 32'h61);
      checkOutput("cr_c1", {24'h0, log_ch[1]}, 32'h0a);
      checkOutput("cr_owner", log_own[0], 2);
    end
    checkDrained("cr_drained");

    // Requester 0 stalls mid-line; the grant must move to requester 1 after the timeout.
    applyReset();
    applyStimulus(4'b0001, chOn(0, 8'h61), 1'b1);
    applyStimulus(4'b0011, chOn(0, 8'h62) | chOn(1, 8'h7a), 1'b1);
    applyStimulus(4'b0011, chOn(0, 8'h63) | chOn(1, 8'h0a), 1'b1);
    applyStimulus('0, '0, 1'b1);
    waitCycles(20);
    applyStimulus(4'b0001, chOn(0, 8'h64), 1'b1);
    applyStimulus(4'b0001, chOn(0, 8'h0a), 1'b1);
    applyStimulus('0, '0, 1'b1);
    waitCycles(10);
    checkOutput("to_count", log_ch.size(), 7);
    if (log_ch.size() == 7) begin
      for (int k = 0; k < 7; k++) begin
        checkOutput("to_char", {24'h0, log_ch[k]}, {24'h0, to_c[k]});
        checkOutput("to_owner", log_own[k], to_o[k]);
      end
      checkOutput("to_release_gap", log_cyc[3] - log_cyc[2], TIMEOUT + 3);
    end
    checkDrained("to_drained");

    // Fill requester 3 with the sink stalled, then reset in mid-stream.
    applyReset();
    for (int k = 0; k < 17; k++) begin
      applyStimulus(4'b1000, chOn(3, 8'h41 + 8'(k)), 1'b0);
      @(negedge clock);
      checkOutput("full_ready", {31'h0, req_ready[3]}, {31'h0, k < 16});
    end
    applyStimulus('0, '0, 1'b0);
    @(negedge clock);
    checkOutput("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("pre_rst_owner", {30'h0, owner}, 32'h3);
    checkOutput("pre_rst_head", {24'h0, out_ch}, 32'h41);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("mid_rst_ch", {24'h0, out_ch}, 32'h0);
    checkOutput("mid_rst_owner_valid", {31'h0, owner_valid}, 32'h0);
    checkOutput("mid_rst_ready", {28'h0, req_ready}, 32'h0);
    clearBook();
    waitCycles(2);
    reset     = 1'b1;
    out_ready = 1'b1;
    waitCycles(20);
    checkOutput("post_rst_silent", log_ch.size(), 0);
    checkOutput("post_rst_ready_all", {28'h0, req_ready}, 32'hf);
    checkOutput("post_rst_idle", {31'h0, owner_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
